// File: rtl/retire_monitor.sv
// Retire-interface monitor: run statistics plus a show-ahead FIFO of retire records.
// RUN counts and buffers; halt or the cycle limit moves to DRAIN, and DONE follows once the FIFO is empty.
module retire_monitor #(
  parameter int DEPTH       = 16,
  parameter int CYCLE_LIMIT = 40000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_retire_valid,
  input  logic [31:0]                i_retire_inst,
  input  logic                       i_retire_trap,
  input  logic                       i_retire_halt,
  input  logic [31:0]                i_retire_pc,
  input  logic [4:0]                 i_retire_rd_waddr,
  input  logic [31:0]                i_retire_rd_wdata,
  input  logic                       i_mispredict,
  input  logic                       i_rd_ready,
  output logic                       o_rd_valid,
  output logic [31:0]                o_rd_pc,
  output logic [31:0]                o_rd_inst,
  output logic [4:0]                 o_rd_waddr,
  output logic [31:0]                o_rd_wdata,
  output logic [1:0]                 o_rd_flags,
  output logic [31:0]                o_cycles,
  output logic [31:0]                o_instret,
  output logic [31:0]                o_branches,
  output logic [31:0]                o_mispredicts,
  output logic [15:0]                o_dropped,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_timeout,
  output logic                       o_done
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [31:0]   LIMIT      = 32'(CYCLE_LIMIT);

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, DONE = 2'd2} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  flags;
  } rec_t;

  function automatic logic is_ctrl_flow(input logic [31:0] inst);
    case (inst[6:0])
      7'b1100011, 7'b1101111, 7'b1100111: is_ctrl_flow = 1'b1;
      default:                            is_ctrl_flow = 1'b0;
    endcase
  endfunction

  state_t      state, state_nx;
  rec_t        mem [DEPTH];
  rec_t        wr_rec, head;
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count, count_nx;
  logic [31:0] cycles, cycles_inc, instret, branches, mispredicts;
  logic [15:0] dropped;
  logic        timeout;
  logic        run, push, pop, full, accept, drop, limit_hit, timeout_set;

  assign run        = (state == RUN);
  assign push       = run & i_retire_valid;
  assign o_rd_valid = (count != {CW{1'b0}}) && (state != DONE);
  assign pop        = o_rd_valid & i_rd_ready;
  assign full       = (count == FULL_COUNT);
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push alongside it.
  assign accept     = push & (~full | pop);
  assign drop       = push & full & ~pop;
  assign cycles_inc = cycles + 32'd1;
  assign limit_hit  = (cycles_inc == LIMIT);

  assign wr_rec = '{pc: i_retire_pc, inst: i_retire_inst, waddr: i_retire_rd_waddr,
                    wdata: i_retire_rd_wdata, flags: {i_retire_halt, i_retire_trap}};
  assign head   = mem[rptr];

  always_comb begin
    count_nx = count;
    case ({accept, pop})
      2'b10:   count_nx = count + CW'(1);
      2'b01:   count_nx = count - CW'(1);
      default: count_nx = count;
    endcase
  end

  always_comb begin
    state_nx    = state;
    timeout_set = 1'b0;
    case (state)
      RUN: begin
        if (i_retire_valid && i_retire_halt) begin
          state_nx = DRAIN;
        end else if (limit_hit) begin
          state_nx    = DRAIN;
          timeout_set = 1'b1;
        end else begin
          state_nx = RUN;
        end
      end
      DRAIN: begin
        if (count_nx == {CW{1'b0}}) state_nx = DONE;
        else                        state_nx = DRAIN;
      end
      DONE:    state_nx = DONE;
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wptr] <= wr_rec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      wptr        <= {AW{1'b0}};
      rptr        <= {AW{1'b0}};
      count       <= {CW{1'b0}};
      cycles      <= 32'd0;
      instret     <= 32'd0;
      branches    <= 32'd0;
      mispredicts <= 32'd0;
      dropped     <= 16'd0;
      timeout     <= 1'b0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      if (run) cycles <= cycles_inc;
      if (push) instret <= instret + 32'd1;
      if (push && is_ctrl_flow(i_retire_inst)) branches <= branches + 32'd1;
      if (run && i_mispredict) mispredicts <= mispredicts + 32'd1;
      if (drop && (dropped != 16'hFFFF)) dropped <= dropped + 16'd1;
      if (accept) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      if (timeout_set) timeout <= 1'b1;
    end
  end

  assign o_rd_pc       = head.pc;
  assign o_rd_inst     = head.inst;
  assign o_rd_waddr    = head.waddr;
  assign o_rd_wdata    = head.wdata;
  assign o_rd_flags    = head.flags;
  assign o_cycles      = cycles;
  assign o_instret     = instret;
  assign o_branches    = branches;
  assign o_mispredicts = mispredicts;
  assign o_dropped     = dropped;
  assign o_count       = count;
  assign o_timeout     = timeout;
  assign o_done        = (state == DONE);
endmodule

// File: doc/retire_monitor.md
Name: retire_monitor

Overview:
- Receiving end of the hart's instruction-retire interface. Turns the per-cycle retire strobe into statistics and a buffered record stream.
- Counts cycles, retired instructions, control-flow instructions and mispredicts.
- Captures retire records into a show-ahead FIFO that a host or bench drains over a valid/ready port.
- Detects end of program, either halt or cycle limit, and signals completion once the FIFO is empty.

Parameters:
DEPTH, 16, FIFO entries; power of 2, minimum 2.
CYCLE_LIMIT, 40000, run cycles before forced stop (timeout).

Ports:
clk  in  1  clock
rst  in  1  reset
i_retire_valid  in  1  one instruction retires this cycle
i_retire_inst  in  32  retired instruction word
i_retire_trap  in  1  instruction trapped
i_retire_halt  in  1  instruction halts hart
i_retire_pc  in  32  pc of retired instruction
i_retire_rd_waddr  in  5  destination register
i_retire_rd_wdata  in  32  destination write data
i_mispredict  in  1  branch mispredict detected this cycle (from hazard unit)
i_rd_ready  in  1  consumer accepts head record
o_rd_valid  out  1  FIFO non-empty
o_rd_pc  out  32  head record pc
o_rd_inst  out  32  head record instruction
o_rd_waddr  out  5  head record rd
o_rd_wdata  out  32  head record rd data
o_rd_flags  out  2  head record {halt, trap}
o_cycles  out  32  cycles counted in RUN
o_instret  out  32  retired instructions counted
o_branches  out  32  retired branch/jal/jalr count
o_mispredicts  out  32  mispredict count
o_dropped  out  16  records lost to full FIFO, saturating
o_count  out  $clog2(DEPTH)+1  FIFO occupancy
o_timeout  out  1  run ended by CYCLE_LIMIT
o_done  out  1  run ended and FIFO drained

Behaviour:
- Reset values:
  - All counters 0; o_count 0; o_rd_valid 0; o_timeout 0; o_done 0.
  - FIFO pointers 0; state RUN.
  - Head data outputs are don't-care while o_rd_valid = 0.
- Reset mid-operation: all state is discarded on the next edge; no record survives.
- States: RUN, DRAIN, DONE.
- RUN:
  - o_cycles increments every cycle, including the cycle a halt retires.
  - On i_retire_valid:
    - o_instret increments.
    - o_branches increments if inst[6:0] is 1100011, 1101111 or 1100111.
    - The record is enqueued.
  - o_mispredicts increments on each i_mispredict cycle, independent of i_retire_valid.
  - Retire with halt=1: go to DRAIN; the halt record is enqueued and counted.
  - Else, if the incremented o_cycles equals CYCLE_LIMIT: go to DRAIN and set o_timeout=1 (sticky).
  - Halt and limit in the same cycle: halt wins, o_timeout stays 0.
- DRAIN:
  - Retire and mispredict inputs are ignored: no counting, no enqueue.
  - Counters freeze.
  - When o_count==0 (after any pop this cycle), go to DONE next edge.
- DONE:
  - o_done=1, sticky until rst.
  - Inputs ignored; o_rd_valid=0.
- FIFO:
  - o_rd_valid = (o_count != 0). Head outputs are driven combinationally from storage at the read pointer.
  - A record retired at edge N is visible on o_rd_valid after edge N (next cycle).
  - Pop when o_rd_valid & i_rd_ready.
  - Push when full and no pop in the same cycle: the record is dropped and o_dropped increments, saturating at 16'hFFFF. o_instret and o_branches still count it.
  - Push when full with a simultaneous pop: the push is accepted and o_count is unchanged.
  - Push and pop when empty: the record goes into storage; the pop is not possible because o_rd_valid=0.
  - Pointers wrap modulo DEPTH; o_count distinguishes full from empty.
- Arithmetic: 32-bit counters wrap modulo 2^32; only o_dropped saturates.

Test Plan:
- Reset then 5 non-branch retires on consecutive cycles, i_rd_ready=0 -> o_instret=5, o_count=5, o_branches=0; first popped record holds the first pc.
- Retires of inst 0x00000063 (beq), 0x0000006F (jal), 0x00000067 (jalr), 0x00000013 (addi), plus 2 i_mispredict pulses -> o_branches=3, o_mispredicts=2, o_instret=4.
- DEPTH=4, 6 retires, no pops -> o_count=4, o_dropped=2, o_instret=6. Then 1 pop concurrent with 1 retire -> o_count stays 4, o_dropped stays 2.
- Halt retired at cycle 10 with 3 records queued, i_rd_ready=1 -> state DRAIN, o_cycles frozen at 10, later retires ignored; o_done=1 the cycle after the last pop; last record o_rd_flags=2'b10.
- CYCLE_LIMIT=20, no halt -> o_cycles=20, o_timeout=1, o_done after drain. Halt on the cycle the limit is hit -> o_timeout=0.
- Assert rst while in DRAIN with records queued -> next cycle o_count=0, o_rd_valid=0, all counters 0, state RUN, o_done=0.
